// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main control unit sequencing FETCH/DECODE/EXEC/MEM/WB/HALT
// Inputs : clk, rst_n (async active-low), instr[31:0] (type=[31:30], func=[29:25]),
//          mem_ready, alu_zero, alu_negative
// Outputs: alu_type/alu_func, alu_src_a/alu_src_b, mem_req/mem_we, ir_write, pc_write,
//          reg_write, flags_write, flag_z/flag_n, illegal (sticky), busy
// Optional: RETIRE_COUNT_EN adds retired_count[31:0], instructions completed since reset
module mc_control_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_negative,
  output logic [1:0]  alu_type,
  output logic [4:0]  alu_func,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        flags_write,
  output logic        flag_z,
  output logic        flag_n,
  output logic        illegal,
  output logic        busy
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0] retired_count
`endif
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_next;
  logic [6:0] r_ir;
  logic [3:0] r_wait;
  logic r_fz, r_fn, r_ill;
  logic [1:0] w_type;
  logic [4:0] w_func;
  logic w_lw, w_sw, w_beq, w_cmp, w_upd, w_ls, w_legal, w_stall, w_tmo, w_unused;
  assign w_type = r_ir[6:5];
  assign w_func = r_ir[4:0];
  assign w_lw = r_ir == 7'b10_00010;
  assign w_sw = r_ir == 7'b10_00011;
  assign w_beq = r_ir == 7'b10_00100;
  assign w_cmp = r_ir == 7'b00_00011;
  assign w_ls = w_lw | w_sw;
  assign w_upd = w_cmp | w_beq | r_ir == 7'b00_00001 | r_ir == 7'b00_00010 | r_ir == 7'b10_00001;
  assign w_legal = (w_type == 2'b00 && w_func <= 5'd3) || (w_type == 2'b10 && w_func <= 5'd4) ||
                   (w_type == 2'b11 && w_func <= 5'd3);
  assign w_stall = mem_req & ~mem_ready;
  // the counter reaches MEM_WAIT_MAX on the edge that ends this stalled cycle
  assign w_tmo = w_stall && r_wait == 4'(MEM_WAIT_MAX - 1);
  assign w_unused = &{1'b0, instr[24:0], PC_STEP != 0};
  assign flag_z = r_fz;
  assign flag_n = r_fn;
  assign illegal = r_ill;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ir <= '0;
      r_wait <= '0;
      r_fz <= 1'b0;
      r_fn <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      r_state <= w_next;
      if (ir_write) r_ir <= instr[31:25];
      r_wait <= w_stall ? r_wait + 4'd1 : 4'd0;
      if (flags_write) {r_fz, r_fn} <= {alu_zero, alu_negative};
      if ((r_state == S_DECODE && !w_legal) || w_tmo) r_ill <= 1'b1;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : w_tmo ? S_HALT : S_FETCH;
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC:   w_next = w_ls ? S_MEM : (w_cmp | w_beq) ? S_FETCH : S_WB;
      S_MEM:    w_next = mem_ready ? (w_sw ? S_FETCH : S_WB) : w_tmo ? S_HALT : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  end
  always_comb begin
    alu_type = 2'b00;
    alu_func = 5'd0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    flags_write = 1'b0;
    busy = r_state != S_HALT;
    case (r_state)
      S_FETCH: begin
        alu_func = 5'd1;
        alu_src_b = 2'd1;
        mem_req = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_func = 5'd1;
        alu_src_b = 2'd3;
      end
      S_EXEC, S_MEM: begin
        alu_type = w_ls ? 2'b00 : w_type;
        alu_func = w_ls ? 5'd1 : w_func;
        alu_src_a = 1'b1;
        alu_src_b = w_type == 2'b10 ? 2'd2 : 2'd0;
        mem_req = r_state == S_MEM;
        mem_we = r_state == S_MEM && w_sw;
        flags_write = r_state == S_EXEC && w_upd;
        pc_write = r_state == S_EXEC && w_beq && alu_zero;
      end
      S_WB: reg_write = 1'b1;
      default: busy = 1'b0;
    endcase
    // outputs take their reset values while rst_n is low, independent of the clock
    if (!rst_n) begin
      {alu_type, alu_func, alu_src_a, alu_src_b} = '0;
      {mem_req, mem_we, ir_write, pc_write, reg_write, flags_write} = '0;
      busy = 1'b1;
    end
  end
`ifdef RETIRE_COUNT_EN
  logic [31:0] r_retired;
  assign retired_count = r_retired;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_retired <= '0;
    else if (w_next == S_FETCH && (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB))
      r_retired <= r_retired + 32'd1;
`endif
endmodule
